// File: rtl/uart_rx_param_if.sv
// Receive-side handshake bundle for uart_rx_param.
//   rx_data    : received word, LSB = first bit on the line
//   rx_valid   : rx_data holds a word not yet accepted
//   rx_ready   : consumer accepts the held word
//   frame_err  : held word had a stop bit sampled low
//   parity_err : held word failed the parity check
// master = receiver (drives the word), slave = consumer (drives rx_ready).
interface uart_rx_param_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 frame_err;
    logic                 parity_err;

    modport master (
        output rx_data, rx_valid, frame_err, parity_err,
        input  rx_ready
    );

    modport slave (
        input  rx_data, rx_valid, frame_err, parity_err,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx_param.sv
// Parameterised UART receiver: start/data/optional parity/stop framing with mid-bit sampling,
// a one-word output holding register with valid/ready handshake and a sticky overrun flag.
// Optional feature: define UART_RX_PARITY_EN to add the parity bit state and parity check.
// Ports:
//   clk     : sole clock, all logic on posedge
//   rst     : synchronous active-high reset, aborts any frame in progress
//   rxd     : asynchronous serial input, idle high
//   ovr_clr : one-cycle pulse that clears overrun (a simultaneous new overrun wins)
//   overrun : sticky, set when a word is dropped because the held word was not accepted
//   busy    : high whenever the receive FSM is not idle
//   bus     : rx_data / rx_valid / rx_ready / frame_err / parity_err handshake (master side)
module uart_rx_param #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned PARITY_ODD   = 0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           rxd,
    input  logic           ovr_clr,
    output logic           overrun,
    output logic           busy,
    uart_rx_param_if.master bus
);
    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] CntHalf = CntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [3:0] DataLast = 4'(DATA_BITS - 1);
    localparam logic [3:0] StopLast = 4'(STOP_BITS - 1);

    if (CLKS_PER_BIT < 4 || DATA_BITS < 5 || DATA_BITS > 9 ||
        (STOP_BITS != 1 && STOP_BITS != 2) || PARITY_ODD > 1) begin : g_bad_cfg
        $error("uart_rx_param: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef UART_RX_PARITY_EN
        StParity,
`endif
        StStop
    } state_e;

    state_e               state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [3:0]           idx_q, idx_d;      // data bit index, reused as stop bit index
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 ferr_acc_q, ferr_acc_d;
    logic                 deliver_q, deliver_d;
    logic                 rxd_meta_q, rxd_s;
    logic [DATA_BITS-1:0] rx_data_q;
    logic                 rx_valid_q, frame_err_q, overrun_q;
`ifdef UART_RX_PARITY_EN
    logic                 perr_acc_q, perr_acc_d;
    logic                 parity_err_q;
`endif

    // Two-flop synchronizer; resets to the idle line level so reset never looks like a start.
    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_meta_q <= 1'b1;
            rxd_s      <= 1'b1;
        end else begin
            rxd_meta_q <= rxd;
            rxd_s      <= rxd_meta_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            idx_q      <= '0;
            shift_q    <= '0;
            ferr_acc_q <= 1'b0;
            deliver_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_acc_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            ferr_acc_q <= ferr_acc_d;
            deliver_q  <= deliver_d;
`ifdef UART_RX_PARITY_EN
            perr_acc_q <= perr_acc_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
        ferr_acc_d = ferr_acc_q;
        deliver_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_acc_d = perr_acc_q;
`endif
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                idx_d = '0;
                if (!rxd_s) begin
                    state_d    = StStart;
                    ferr_acc_d = 1'b0;
                end
            end
            StStart: begin
                if (cnt_q == CntHalf) begin
                    // Line back high at mid start bit: a glitch, not a frame.
                    cnt_d   = '0;
                    state_d = rxd_s ? StIdle : StData;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StData: begin
                if (cnt_q == CntLast) begin
                    cnt_d   = '0;
                    shift_d = {rxd_s, shift_q[DATA_BITS-1:1]};
                    if (idx_q == DataLast) begin
                        idx_d = '0;
`ifdef UART_RX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            StParity: begin
                if (cnt_q == CntLast) begin
                    cnt_d      = '0;
                    perr_acc_d = (^shift_q ^ rxd_s) != 1'(PARITY_ODD);
                    state_d    = StStop;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            StStop: begin
                if (cnt_q == CntLast) begin
                    cnt_d = '0;
                    if (!rxd_s) ferr_acc_d = 1'b1;
                    if (idx_q == StopLast) begin
                        // Leave at mid stop bit so the next start edge is caught immediately.
                        idx_d     = '0;
                        state_d   = StIdle;
                        deliver_d = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output holding register; a delivery while the held word is still pending is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            if (deliver_q) begin
                if (!rx_valid_q || bus.rx_ready) begin
                    rx_data_q    <= shift_q;
                    frame_err_q  <= ferr_acc_q;
                    rx_valid_q   <= 1'b1;
`ifdef UART_RX_PARITY_EN
                    parity_err_q <= perr_acc_q;
`endif
                end
            end else if (rx_valid_q && bus.rx_ready) begin
                rx_valid_q <= 1'b0;
            end
            if (deliver_q && rx_valid_q && !bus.rx_ready) begin
                overrun_q <= 1'b1;
            end else if (ovr_clr) begin
                overrun_q <= 1'b0;
            end
        end
    end

    assign bus.rx_data   = rx_data_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.frame_err = frame_err_q;
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err = parity_err_q;
`else
    assign bus.parity_err = 1'b0;
`endif
    assign overrun = overrun_q;
    assign busy    = (state_q != StIdle);
endmodule

// File: tb/tb_uart_rx_param.sv
module tb_uart_rx_param;
    localparam int unsigned CPB = 8;
    localparam int unsigned DB  = 8;
    localparam int unsigned SB  = 1;
    localparam int unsigned PO  = 0;
`ifdef UART_RX_PARITY_EN
    localparam int unsigned PB  = 1;
`else
    localparam int unsigned PB  = 0;
`endif

    logic clk = 1'b0;
    logic rst, rxd, ovr_clr, overrun, busy;

    uart_rx_param_if #(.DATA_BITS(DB)) bus ();

    uart_rx_param #(
        .CLKS_PER_BIT(CPB),
        .DATA_BITS(DB),
        .STOP_BITS(SB),
        .PARITY_ODD(PO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rxd(rxd),
        .ovr_clr(ovr_clr),
        .overrun(overrun),
        .busy(busy),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          perr;
        logic          ferr;
        logic [DB-1:0] data;
    } word_t;

    int    n_checks = 0;
    int    n_fail = 0;
    int    valid_cycles = 0;
    word_t exp_q[$];
    word_t got_q[$];

    // Record every accepted word (valid && ready) and count cycles with valid high.
    always @(posedge clk) begin
        word_t w;
        #1;
        if (bus.rx_valid === 1'b1) valid_cycles++;
        if (bus.rx_valid === 1'b1 && bus.rx_ready === 1'b1) begin
            w.perr = bus.parity_err;
            w.ferr = bus.frame_err;
            w.data = bus.rx_data;
            got_q.push_back(w);
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    // Hold one line level for a full bit period; called and returns on a negedge.
    task automatic drive_bit(input logic b);
        rxd = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic idle_bits(input int n);
        rxd = 1'b1;
        repeat (n * CPB) @(negedge clk);
    endtask

    // Serialise one frame and push the word the receiver should report.
    task automatic send_frame(input logic [DB-1:0] d, input logic stop_ok, input logic par_ok);
        word_t w;
        logic  po_bit;
        po_bit = 1'(PO);
        drive_bit(1'b0);
        for (int i = 0; i < DB; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(^d ^ po_bit ^ ~par_ok);
        w.perr = ~par_ok;
`else
        w.perr = 1'b0;
`endif
        for (int s = 0; s < SB; s++) drive_bit(stop_ok);
        rxd = 1'b1;
        w.ferr = ~stop_ok;
        w.data = d;
        exp_q.push_back(w);
    endtask

    task automatic clear_queues();
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rxd = 1'b1;
        ovr_clr = 1'b0;
        bus.rx_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.rx_data !== 8'h00) begin n_fail++;
            $display("FAIL reset_rx_data: got %0h required 0", bus.rx_data); end
        n_checks++; if (bus.rx_valid !== 1'b0) begin n_fail++;
            $display("FAIL reset_rx_valid: got %b required 0", bus.rx_valid); end
        n_checks++; if (bus.frame_err !== 1'b0) begin n_fail++;
            $display("FAIL reset_frame_err: got %b required 0", bus.frame_err); end
        n_checks++; if (bus.parity_err !== 1'b0) begin n_fail++;
            $display("FAIL reset_parity_err: got %b required 0", bus.parity_err); end
        n_checks++; if (overrun !== 1'b0) begin n_fail++;
            $display("FAIL reset_overrun: got %b required 0", overrun); end
        n_checks++; if (busy !== 1'b0) begin n_fail++;
            $display("FAIL reset_busy: got %b required 0", busy); end
    endtask

    // Cycle 0 is the first clock edge that samples rxd low.
    task automatic test_latency();
        int n;
        int exp_lat;
        logic seen;
        exp_lat = 2 + CPB / 2 + (DB + PB + SB) * CPB + 1;
        n = 0;
        seen = 1'b0;
        bus.rx_ready = 1'b0;
        fork
            send_frame(8'h55, 1'b1, 1'b1);
            begin
                while (!seen && n < 400) begin
                    @(posedge clk);
                    #1;
                    if (bus.rx_valid === 1'b1) seen = 1'b1;
                    else n++;
                end
            end
        join
        n_checks++; if (!seen || n != exp_lat) begin n_fail++;
            $display("FAIL latency: got %0d cycles (seen=%b) required %0d", n, seen, exp_lat); end
        n_checks++; if (bus.rx_data !== 8'h55) begin n_fail++;
            $display("FAIL latency_data: got %0h required 55", bus.rx_data); end
        n_checks++; if (bus.frame_err !== 1'b0) begin n_fail++;
            $display("FAIL latency_frame_err: got %b required 0", bus.frame_err); end
        @(negedge clk);
        bus.rx_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (bus.rx_valid !== 1'b0) begin n_fail++;
            $display("FAIL handshake_clear: got %b required 0", bus.rx_valid); end
        n_checks++; if (bus.rx_data !== 8'h55) begin n_fail++;
            $display("FAIL handshake_hold_data: got %0h required 55", bus.rx_data); end
        clear_queues();
    endtask

    task automatic test_frame_err();
        bus.rx_ready = 1'b1;
        clear_queues();
        send_frame(8'hA3, 1'b0, 1'b1);
        idle_bits(2);
        send_frame(8'h0F, 1'b1, 1'b1);
        idle_bits(2);
        n_checks++; if (got_q.size() != exp_q.size()) begin n_fail++;
            $display("FAIL frame_err_count: got %0d words required %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++;
                $display("FAIL frame_err_word%0d: got %0h required %0h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_random();
        logic [DB-1:0] d;
        logic stop_ok, par_ok;
        int gap;
        bus.rx_ready = 1'b1;
        clear_queues();
        for (int k = 0; k < 12; k++) begin
            d = DB'($urandom_range(0, (1 << DB) - 1));
            stop_ok = ($urandom_range(0, 3) != 0);
            par_ok = 1'b1;
`ifdef UART_RX_PARITY_EN
            par_ok = ($urandom_range(0, 2) != 0);
`endif
            send_frame(d, stop_ok, par_ok);
            // A low stop bit needs idle line before the next start edge.
            gap = stop_ok ? int'($urandom_range(0, 2)) : 2;
            idle_bits(gap);
        end
        idle_bits(2);
        n_checks++; if (got_q.size() != exp_q.size()) begin n_fail++;
            $display("FAIL random_count: got %0d words required %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++;
                $display("FAIL random_word%0d: got %0h required %0h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_back_to_back();
        bus.rx_ready = 1'b1;
        clear_queues();
        valid_cycles = 0;
        send_frame(8'h01, 1'b1, 1'b1);
        send_frame(8'h02, 1'b1, 1'b1);
        send_frame(8'h03, 1'b1, 1'b1);
        idle_bits(2);
        n_checks++; if (valid_cycles != 3) begin n_fail++;
            $display("FAIL b2b_valid_cycles: got %0d required 3", valid_cycles); end
        n_checks++; if (overrun !== 1'b0) begin n_fail++;
            $display("FAIL b2b_overrun: got %b required 0", overrun); end
        n_checks++; if (got_q.size() != exp_q.size()) begin n_fail++;
            $display("FAIL b2b_count: got %0d words required %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++;
                $display("FAIL b2b_word%0d: got %0h required %0h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_overrun();
        logic seen;
        bus.rx_ready = 1'b0;
        clear_queues();
        send_frame(8'h11, 1'b1, 1'b1);
        idle_bits(1);
        send_frame(8'h22, 1'b1, 1'b1);
        idle_bits(2);
        n_checks++; if (bus.rx_data !== 8'h11 || bus.rx_valid !== 1'b1) begin n_fail++;
            $display("FAIL overrun_held: got data %0h valid %b required 11/1", bus.rx_data,
                     bus.rx_valid); end
        n_checks++; if (overrun !== 1'b1) begin n_fail++;
            $display("FAIL overrun_set: got %b required 1", overrun); end
        ovr_clr = 1'b1;
        @(negedge clk);
        ovr_clr = 1'b0;
        @(negedge clk);
        n_checks++; if (overrun !== 1'b0) begin n_fail++;
            $display("FAIL overrun_clear: got %b required 0", overrun); end
        // Hold ovr_clr through another dropped delivery: the set must win.
        seen = 1'b0;
        ovr_clr = 1'b1;
        fork
            send_frame(8'h33, 1'b1, 1'b1);
            begin
                for (int c = 0; c < 20 * CPB && !seen; c++) begin
                    @(posedge clk);
                    #1;
                    if (overrun === 1'b1) seen = 1'b1;
                end
                @(negedge clk);
                ovr_clr = 1'b0;
            end
        join
        idle_bits(1);
        n_checks++; if (!seen || overrun !== 1'b1) begin n_fail++;
            $display("FAIL overrun_set_wins: got seen=%b overrun=%b required 1/1", seen, overrun); end
        n_checks++; if (bus.rx_data !== 8'h11) begin n_fail++;
            $display("FAIL overrun_keep_data: got %0h required 11", bus.rx_data); end
        ovr_clr = 1'b1;
        bus.rx_ready = 1'b1;
        @(negedge clk);
        ovr_clr = 1'b0;
        @(negedge clk);
        clear_queues();
    endtask

    task automatic test_glitch();
        bus.rx_ready = 1'b1;
        clear_queues();
        valid_cycles = 0;
        rxd = 1'b0;
        repeat (2) @(negedge clk);
        rxd = 1'b1;
        @(negedge clk);
        n_checks++; if (busy !== 1'b1) begin n_fail++;
            $display("FAIL glitch_start_seen: got busy %b required 1", busy); end
        idle_bits(3);
        n_checks++; if (busy !== 1'b0) begin n_fail++;
            $display("FAIL glitch_back_idle: got busy %b required 0", busy); end
        n_checks++; if (valid_cycles != 0 || got_q.size() != 0) begin n_fail++;
            $display("FAIL glitch_no_word: got %0d valid cycles %0d words required 0/0",
                     valid_cycles, got_q.size()); end
    endtask

    task automatic test_reset_mid();
        bus.rx_ready = 1'b0;
        send_frame(8'h5A, 1'b0, 1'b1);
        idle_bits(2);
        send_frame(8'h5A, 1'b1, 1'b1);
        idle_bits(1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        rst = 1'b1;
        rxd = 1'b1;
        @(negedge clk);
        n_checks++; if (bus.rx_data !== 8'h00 || bus.rx_valid !== 1'b0) begin n_fail++;
            $display("FAIL rst_mid_word: got data %0h valid %b required 0/0", bus.rx_data,
                     bus.rx_valid); end
        n_checks++; if (bus.frame_err !== 1'b0 || bus.parity_err !== 1'b0) begin n_fail++;
            $display("FAIL rst_mid_flags: got ferr %b perr %b required 0/0", bus.frame_err,
                     bus.parity_err); end
        n_checks++; if (overrun !== 1'b0 || busy !== 1'b0) begin n_fail++;
            $display("FAIL rst_mid_ovr_busy: got ovr %b busy %b required 0/0", overrun, busy); end
        rst = 1'b0;
        idle_bits(2);
        bus.rx_ready = 1'b1;
        clear_queues();
        send_frame(8'hC3, 1'b1, 1'b1);
        idle_bits(2);
        n_checks++; if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin n_fail++;
            $display("FAIL rst_mid_recover: got %0d words first %0h required 1 word %0h",
                     got_q.size(), (got_q.size() > 0) ? got_q[0] : '0, exp_q[0]); end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        bus.rx_ready = 1'b1;
        clear_queues();
        send_frame(8'h07, 1'b1, 1'b0);
        idle_bits(1);
        send_frame(8'h07, 1'b1, 1'b1);
        idle_bits(2);
        n_checks++; if (got_q.size() != exp_q.size()) begin n_fail++;
            $display("FAIL parity_count: got %0d words required %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++;
                $display("FAIL parity_word%0d: got %0h required %0h", i, got_q[i], exp_q[i]); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_latency();
        test_frame_err();
        test_back_to_back();
        test_overrun();
        test_glitch();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
